// File: rtl/ddr5_cmd_pkg.sv
// Command codes, FSM state encodings and default timings shared by the
// closed-page sequencer and the downstream CA packet generator.
package ddr5_cmd_pkg;

  localparam logic [3:0] CMD_IDLE = 4'd0;
  localparam logic [3:0] CMD_WRP  = 4'd1;
  localparam logic [3:0] CMD_MRW  = 4'd2;
  localparam logic [3:0] CMD_WRPA = 4'd3;
  localparam logic [3:0] CMD_RD   = 4'd4;
  localparam logic [3:0] CMD_WRA  = 4'd5;
  localparam logic [3:0] CMD_MRR  = 4'd6;
  localparam logic [3:0] CMD_WR   = 4'd7;
  localparam logic [3:0] CMD_ACT  = 4'd8;
  localparam logic [3:0] CMD_RDA  = 4'd12;
  localparam logic [3:0] CMD_PRE  = 4'd13;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_ACT1 = 3'd1;
  localparam state_t S_ACT2 = 3'd2;
  localparam state_t S_WRCD = 3'd3;
  localparam state_t S_CAS1 = 3'd4;
  localparam state_t S_CAS2 = 3'd5;
  localparam state_t S_WRC  = 3'd6;

  localparam int T_RCD_DEF = 6;
  localparam int T_RC_DEF  = 16;
  localparam int CNT_W_DEF = 6;

  // Only ACT and the auto-precharge CAS codes are ever produced.
  function automatic logic [3:0] state_code(input state_t s, input logic is_wr);
    case (s)
      S_ACT1, S_ACT2: state_code = CMD_ACT;
      S_CAS1, S_CAS2: state_code = is_wr ? CMD_WRA : CMD_RDA;
      default:        state_code = CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ddr5_tmr.sv
// Loadable down-counter that saturates at zero; done is high while the
// count is zero, so a reset timer reads as already satisfied.
module ddr5_tmr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ddr5_cmd_seq.sv
// Closed-page sequencer: one request becomes ACT then RDA/WRA, each command
// two cycles long, with tRCD and tRC enforced by two down-counters.
module ddr5_cmd_seq
  import ddr5_cmd_pkg::*;
#(
  parameter int T_RCD = T_RCD_DEF,
  parameter int T_RC  = T_RC_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_write,
  input  logic [2:0]  req_bg,
  input  logic        req_ba,
  input  logic [15:0] req_row,
  input  logic [9:0]  req_col,
  output logic [3:0]  current_state,
  output logic [2:0]  BG,
  output logic        BA,
  output logic [15:0] row,
  output logic [9:0]  col,
  output logic        CS_i,
  output logic        cas_done,
  output logic        cas_is_write,
  output logic        busy
);

  // Handshake: a request transfers at the rising edge where req_valid and
  // req_ready are both high; fields are sampled only at that edge.
  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [3:0]  code_q;
  logic        cs_n_q, done_q, cwr_q;
  logic [2:0]  bg_q;
  logic        ba_q;
  logic [15:0] row_q;
  logic [9:0]  col_q;
  logic        rcd_done, rc_done, accept;

  // Ready in CAS2 only matters when T_RC == T_RCD+2 and tRC ends there.
  assign req_ready = !rst && ((state_q == S_IDLE) ||
                     (((state_q == S_WRC) || (state_q == S_CAS2)) && rc_done));
  assign accept    = req_valid && req_ready;
  assign busy      = !req_ready && !rst;

  ddr5_tmr #(.W(CNT_W)) u_trcd (
    .clk(clk), .rst(rst), .load(accept),
    .load_val(CNT_W'(T_RCD - 1)), .done(rcd_done)
  );

  ddr5_tmr #(.W(CNT_W)) u_trc (
    .clk(clk), .rst(rst), .load(accept),
    .load_val(CNT_W'(T_RC - 1)), .done(rc_done)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = accept ? req_is_write : wr_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ACT1;
      S_ACT1: state_d = S_ACT2;
      S_ACT2: state_d = rcd_done ? S_CAS1 : S_WRCD;
      S_WRCD: if (rcd_done) state_d = S_CAS1;
      S_CAS1: state_d = S_CAS2;
      S_CAS2: state_d = accept ? S_ACT1 : S_WRC;
      S_WRC: begin
        if (accept)       state_d = S_ACT1;
        else if (rc_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      code_q  <= CMD_IDLE;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      cwr_q   <= 1'b0;
      bg_q    <= '0;
      ba_q    <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      code_q  <= state_code(state_d, wr_d);
      cs_n_q  <= !((state_d == S_ACT1) || (state_d == S_CAS1));
      done_q  <= (state_d == S_CAS2);
      cwr_q   <= (state_d == S_CAS2) && wr_d;
      if (accept) begin
        bg_q  <= req_bg;
        ba_q  <= req_ba;
        row_q <= req_row;
        col_q <= req_col;
      end
    end
  end

  assign current_state = code_q;
  assign CS_i          = cs_n_q;
  assign cas_done      = done_q;
  assign cas_is_write  = cwr_q;
  assign BG            = bg_q;
  assign BA            = ba_q;
  assign row           = row_q;
  assign col           = col_q;

endmodule

// File: tb/tb_ddr5_cmd_seq.sv
// Bench for ddr5_cmd_seq: a default-timing instance (6/16) and a
// minimum-timing instance (2/4) share stimulus, each with its own scoreboard.
module tb_ddr5_cmd_seq;

  localparam int W     = 39;
  localparam int RCD_A = 6;
  localparam int RC_A  = 16;
  localparam int RCD_B = 2;
  localparam int RC_B  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_is_write;
  logic [2:0]  req_bg;
  logic        req_ba;
  logic [15:0] req_row;
  logic [9:0]  req_col;

  logic        a_rdy, a_cs, a_done, a_cwr, a_busy, a_ba;
  logic [3:0]  a_code;
  logic [2:0]  a_bg;
  logic [15:0] a_row;
  logic [9:0]  a_col;
  logic        b_rdy, b_cs, b_done, b_cwr, b_busy, b_ba;
  logic [3:0]  b_code;
  logic [2:0]  b_bg;
  logic [15:0] b_row;
  logic [9:0]  b_col;

  always #5 clk = ~clk;

  ddr5_cmd_seq #(.T_RCD(RCD_A), .T_RC(RC_A), .CNT_W(6)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_rdy),
    .req_is_write(req_is_write), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col), .current_state(a_code),
    .BG(a_bg), .BA(a_ba), .row(a_row), .col(a_col), .CS_i(a_cs),
    .cas_done(a_done), .cas_is_write(a_cwr), .busy(a_busy)
  );

  ddr5_cmd_seq #(.T_RCD(RCD_B), .T_RC(RC_B), .CNT_W(6)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_rdy),
    .req_is_write(req_is_write), .req_bg(req_bg), .req_ba(req_ba),
    .req_row(req_row), .req_col(req_col), .current_state(b_code),
    .BG(b_bg), .BA(b_ba), .row(b_row), .col(b_col), .CS_i(b_cs),
    .cas_done(b_done), .cas_is_write(b_cwr), .busy(b_busy)
  );

  logic [W-1:0] act_a, act_b;
  assign act_a = {a_code, a_cs, a_done, a_cwr, a_rdy, a_busy, a_bg, a_ba, a_row, a_col};
  assign act_b = {b_code, b_cs, b_done, b_cwr, b_rdy, b_busy, b_bg, b_ba, b_row, b_col};

  typedef struct {
    logic        wr;
    logic [2:0]  bg;
    logic        ba;
    logic [15:0] row;
    logic [9:0]  col;
    logic [3:0]  exp_cas;
    int          idle_before;
  } vec_t;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qb[$];
  logic [29:0]  lat_a, lat_b;
  logic [3:0]   cur_cas;
  logic         acc_a;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  vec_t         vecs[6];

  // Expected outputs k cycles after an accept, built from A-relative timing.
  function automatic logic [W-1:0] rec(input int rcd, input int rc, input int k,
                                       input logic [3:0] cas, input logic [29:0] addr);
    logic [3:0] code;
    logic       cs, dn, cw, rdy;
    code = (k < 2) ? 4'd8 : ((k == rcd) || (k == rcd + 1)) ? cas : 4'd0;
    cs   = !((k == 0) || (k == rcd));
    dn   = (k == rcd + 1);
    cw   = dn && (cas == 4'd5);
    rdy  = (k == rc - 1);
    return {code, cs, dn, cw, rdy, !rdy, addr};
  endfunction

  function automatic logic [W-1:0] idle_rec(input logic [29:0] addr);
    return {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, addr};
  endfunction

  task automatic check(input string name, input logic [W-1:0] exp, input logic [W-1:0] act);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle, queue expectations for any new command, then compare.
  task automatic cycle(input logic r, input logic v);
    logic [29:0] f;
    f = {req_bg, req_ba, req_row, req_col};
    rst       = r;
    req_valid = v;
    acc_a     = 1'b0;
    if (r) begin
      exp_q.delete();
      exp_qb.delete();
      lat_a = '0;
      lat_b = '0;
      exp_q.push_back({4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0});
      exp_qb.push_back({4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'd0});
    end else begin
      if (exp_q.size() == 0) begin
        if (v) begin
          lat_a = f;
          acc_a = 1'b1;
          for (int k = 0; k < RC_A; k++) exp_q.push_back(rec(RCD_A, RC_A, k, cur_cas, f));
        end else begin
          exp_q.push_back(idle_rec(lat_a));
        end
      end
      if (exp_qb.size() == 0) begin
        if (v) begin
          lat_b = f;
          for (int k = 0; k < RC_B; k++) exp_qb.push_back(rec(RCD_B, RC_B, k, cur_cas, f));
        end else begin
          exp_qb.push_back(idle_rec(lat_b));
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("dut_a_outputs", exp_q.pop_front(), act_a);
    check("dut_b_outputs", exp_qb.pop_front(), act_b);
  endtask

  task automatic set_req(input logic wr, input logic [2:0] bg, input logic ba,
                         input logic [15:0] r, input logic [9:0] c, input logic [3:0] cas);
    req_is_write = wr;
    req_bg       = bg;
    req_ba       = ba;
    req_row      = r;
    req_col      = c;
    cur_cas      = cas;
  endtask

  // Hold valid until the default instance accepts, within a cycle budget.
  task automatic wait_accept();
    int t;
    t = 0;
    do begin
      cycle(1'b0, 1'b1);
      t++;
    end while (!acc_a && t < 64);
    if (!acc_a) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept expected=accept", cyc);
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd3, 1'b1, 16'h1234, 10'h2A8, 4'd12, 2};
    vecs[1] = '{1'b1, 3'd3, 1'b1, 16'h1234, 10'h2A8, 4'd5, 3};
    vecs[2] = '{1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 65535)), 10'($urandom_range(0, 1023)), 4'd12, 0};
    vecs[3] = '{1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 65535)), 10'($urandom_range(0, 1023)), 4'd5, 0};
    vecs[4] = '{1'b1, 3'd7, 1'b0, 16'hFFFF, 10'h3FF, 4'd5, 1};
    vecs[5] = '{1'b0, 3'd0, 1'b0, 16'h0000, 10'h000, 4'd12, 0};

    set_req(1'b0, 3'd0, 1'b0, 16'd0, 10'd0, 4'd12);
    lat_a = '0;
    lat_b = '0;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].idle_before; j++) cycle(1'b0, 1'b0);
      set_req(vecs[i].wr, vecs[i].bg, vecs[i].ba, vecs[i].row, vecs[i].col, vecs[i].exp_cas);
      wait_accept();
    end
    repeat (RC_A) cycle(1'b0, 1'b0);

    // Valid held while not ready, with the row changing under it.
    set_req(1'b0, 3'd5, 1'b0, 16'hBEEF, 10'h155, 4'd12);
    wait_accept();
    for (int j = 0; j < 4; j++) begin
      req_row = 16'($urandom_range(0, 65535));
      cycle(1'b0, 1'b1);
    end
    repeat (RC_A) cycle(1'b0, 1'b0);

    // Reset landing during CAS1, then a fresh request.
    set_req(1'b1, 3'd2, 1'b1, 16'h0F0F, 10'h0AA, 4'd5);
    wait_accept();
    repeat (RCD_A) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    set_req(1'b0, 3'd6, 1'b0, 16'h4321, 10'h123, 4'd12);
    wait_accept();

    // Reset landing during ACT2.
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    set_req(1'b1, 3'd1, 1'b1, 16'hA5A5, 10'h2C3, 4'd5);
    wait_accept();
    repeat (RC_A + 2) cycle(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
